// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: FSM state encoding and default squash length.
package branch_resolve_unit_pkg;

    typedef enum logic {
        BRU_IDLE   = 1'b0,
        BRU_SQUASH = 1'b1
    } bru_state_t;

    localparam int unsigned BRU_FLUSH_CYCLES = 2;

endpackage

// File: rtl/branch_resolve_unit_event_counter.sv
// Wrapping event counter with increment enable and asynchronous reset.
module bru_event_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage control-transfer resolver: predictor update, fetch redirect and wrong-path squash.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = BRU_FLUSH_CYCLES,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic                 ex_stall,
    input  logic [31:0]          ex_pc,
    input  logic [31:0]          ex_pred_pc,
    input  logic                 ex_is_branch,
    input  logic                 ex_is_jal,
    input  logic                 ex_is_jalr,
    input  logic                 ex_taken,
    input  logic [31:0]          ex_target,
    output logic                 update_pred,
    output logic [31:0]          branch_inst_address,
    output logic [31:0]          resolved_next_pc,
    output logic                 predictor_wrong,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic                 flush,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    bru_state_t  state, state_next;
    logic [3:0]  sq_cnt, sq_cnt_next;
    logic [31:0] actual_pc;
    logic        resolve;
    logic        mispredict;

    assign resolve = ex_valid & ~ex_stall & (ex_is_branch | ex_is_jal | ex_is_jalr)
                   & (state == BRU_IDLE);

    // Decode priority JALR > JAL > branch when several flags are set.
    always_comb begin
        actual_pc = ex_pc + 32'd4;
        if (ex_is_jalr) begin
            actual_pc = ex_target & ~32'd1;
        end else if (ex_is_jal) begin
            actual_pc = ex_target;
        end else if (ex_is_branch && ex_taken) begin
            actual_pc = ex_target;
        end
    end

    assign mispredict = (actual_pc != ex_pred_pc);

    always_comb begin
        state_next  = state;
        sq_cnt_next = sq_cnt;
        case (state)
            BRU_IDLE: begin
                if (resolve && mispredict) begin
                    state_next  = BRU_SQUASH;
                    sq_cnt_next = 4'(FLUSH_CYCLES);
                end
            end
            BRU_SQUASH: begin
                sq_cnt_next = sq_cnt - 4'd1;
                if (sq_cnt == 4'd1) begin
                    state_next = BRU_IDLE;
                end
            end
            default: begin
                state_next  = BRU_IDLE;
                sq_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= BRU_IDLE;
            sq_cnt              <= '0;
            update_pred         <= 1'b0;
            branch_inst_address <= '0;
            resolved_next_pc    <= '0;
            predictor_wrong     <= 1'b0;
            redirect_valid      <= 1'b0;
            redirect_pc         <= '0;
        end else begin
            state          <= state_next;
            sq_cnt         <= sq_cnt_next;
            update_pred    <= resolve;
            // Only the entry into SQUASH raises redirect_valid, so it covers its first cycle alone.
            redirect_valid <= resolve & mispredict;
            if (resolve) begin
                branch_inst_address <= ex_pc;
                resolved_next_pc    <= actual_pc;
                predictor_wrong     <= mispredict;
            end
            if (resolve && mispredict) begin
                redirect_pc <= actual_pc;
            end
        end
    end

    assign flush = (state == BRU_SQUASH);

    bru_event_counter #(.WIDTH(CNT_WIDTH)) u_branch_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (resolve),
        .count (branch_count)
    );

    bru_event_counter #(.WIDTH(CNT_WIDTH)) u_mispredict_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (resolve & mispredict),
        .count (mispredict_count)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit: vector table plus stall, squash and reset sequences.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_stall;
    logic [31:0] ex_pc;
    logic [31:0] ex_pred_pc;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        update_pred;
    logic [31:0] branch_inst_address;
    logic [31:0] resolved_next_pc;
    logic        predictor_wrong;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int unsigned n_checks;
    int unsigned n_fail;
    logic [31:0] exp_bc;
    logic [31:0] exp_mc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pred;
        logic [31:0] target;
        logic        br;
        logic        jal;
        logic        jalr;
        logic        taken;
        logic [31:0] exp_next;
        logic        exp_wrong;
    } vec_t;

    localparam int unsigned NVEC = 8;
    vec_t vecs [NVEC];

    branch_resolve_unit #(
        .FLUSH_CYCLES (2),
        .CNT_WIDTH    (32)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ex_valid            (ex_valid),
        .ex_stall            (ex_stall),
        .ex_pc               (ex_pc),
        .ex_pred_pc          (ex_pred_pc),
        .ex_is_branch        (ex_is_branch),
        .ex_is_jal           (ex_is_jal),
        .ex_is_jalr          (ex_is_jalr),
        .ex_taken            (ex_taken),
        .ex_target           (ex_target),
        .update_pred         (update_pred),
        .branch_inst_address (branch_inst_address),
        .resolved_next_pc    (resolved_next_pc),
        .predictor_wrong     (predictor_wrong),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .flush               (flush),
        .branch_count        (branch_count),
        .mispredict_count    (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid     = 1'b0;
        ex_stall     = 1'b0;
        ex_pc        = '0;
        ex_pred_pc   = '0;
        ex_is_branch = 1'b0;
        ex_is_jal    = 1'b0;
        ex_is_jalr   = 1'b0;
        ex_taken     = 1'b0;
        ex_target    = '0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] pred, input logic [31:0] target,
                         input logic br, input logic jal, input logic jalr, input logic taken);
        ex_valid     = 1'b1;
        ex_stall     = 1'b0;
        ex_pc        = pc;
        ex_pred_pc   = pred;
        ex_target    = target;
        ex_is_branch = br;
        ex_is_jal    = jal;
        ex_is_jalr   = jalr;
        ex_taken     = taken;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, ".branch_count"}, branch_count, exp_bc);
        chk({tag, ".mispredict_count"}, mispredict_count, exp_mc);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_bc   = '0;
        exp_mc   = '0;

        //        pc            pred          target        br    jal   jalr  taken exp_next      wrong
        vecs[0] = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0500, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0104, 1'b0};
        vecs[1] = '{32'h0000_0300, 32'h0000_1000, 32'h0000_1000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1000, 1'b0};
        vecs[2] = '{32'h0000_0200, 32'h0000_0204, 32'h0000_0180, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0180, 1'b1};
        vecs[3] = '{32'h0000_0400, 32'h0000_3000, 32'h0000_3001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3000, 1'b0};
        vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        vecs[5] = '{32'h0000_0500, 32'h0000_2002, 32'h0000_2003, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_2002, 1'b0};
        vecs[6] = '{32'h0000_0600, 32'h0000_0604, 32'h0000_0800, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0800, 1'b1};
        vecs[7] = '{32'h0000_0700, 32'h0000_5555, 32'h0000_5555, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_5554, 1'b1};

        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("reset.update_pred", {31'd0, update_pred}, 32'd0);
        chk("reset.flush", {31'd0, flush}, 32'd0);
        chk("reset.redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("reset.resolved_next_pc", resolved_next_pc, 32'd0);
        chk_counters("reset");
        rst = 1'b0;

        for (int i = 0; i < int'(NVEC); i++) begin
            drive(vecs[i].pc, vecs[i].pred, vecs[i].target,
                  vecs[i].br, vecs[i].jal, vecs[i].jalr, vecs[i].taken);
            tick();
            exp_bc++;
            if (vecs[i].exp_wrong) exp_mc++;
            chk($sformatf("vec%0d.update_pred", i), {31'd0, update_pred}, 32'd1);
            chk($sformatf("vec%0d.branch_inst_address", i), branch_inst_address, vecs[i].pc);
            chk($sformatf("vec%0d.resolved_next_pc", i), resolved_next_pc, vecs[i].exp_next);
            chk($sformatf("vec%0d.predictor_wrong", i), {31'd0, predictor_wrong}, {31'd0, vecs[i].exp_wrong});
            chk($sformatf("vec%0d.flush", i), {31'd0, flush}, {31'd0, vecs[i].exp_wrong});
            chk($sformatf("vec%0d.redirect_valid", i), {31'd0, redirect_valid}, {31'd0, vecs[i].exp_wrong});
            chk_counters($sformatf("vec%0d", i));
            if (vecs[i].exp_wrong) begin
                chk($sformatf("vec%0d.redirect_pc", i), redirect_pc, vecs[i].exp_next);
                // Wrong-path mispredicting JAL presented throughout the squash window.
                drive(32'h0000_0A00, 32'h0000_0000, 32'h9999_0000, 1'b0, 1'b1, 1'b0, 1'b0);
                tick();
                chk($sformatf("vec%0d.sq1.flush", i), {31'd0, flush}, 32'd1);
                chk($sformatf("vec%0d.sq1.redirect_valid", i), {31'd0, redirect_valid}, 32'd0);
                chk($sformatf("vec%0d.sq1.update_pred", i), {31'd0, update_pred}, 32'd0);
                tick();
                chk($sformatf("vec%0d.sq2.flush", i), {31'd0, flush}, 32'd0);
                chk($sformatf("vec%0d.sq2.update_pred", i), {31'd0, update_pred}, 32'd0);
                chk($sformatf("vec%0d.sq2.redirect_pc", i), redirect_pc, vecs[i].exp_next);
                chk_counters($sformatf("vec%0d.sq2", i));
                clear_inputs();
            end
        end
        clear_inputs();
        tick();
        chk("idle.update_pred", {31'd0, update_pred}, 32'd0);
        chk("idle.data_hold", resolved_next_pc, 32'h0000_5554);

        // JALR held by a 3-cycle stall must resolve exactly once.
        drive(32'h0000_0900, 32'h0000_3000, 32'h0000_3001, 1'b0, 1'b0, 1'b1, 1'b0);
        ex_stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("stall%0d.update_pred", s), {31'd0, update_pred}, 32'd0);
        end
        chk_counters("stall");
        ex_stall = 1'b0;
        tick();
        exp_bc++;
        chk("release.update_pred", {31'd0, update_pred}, 32'd1);
        chk("release.resolved_next_pc", resolved_next_pc, 32'h0000_3000);
        chk("release.predictor_wrong", {31'd0, predictor_wrong}, 32'd0);
        chk("release.branch_inst_address", branch_inst_address, 32'h0000_0900);
        chk_counters("release");
        clear_inputs();
        tick();
        chk("post_release.update_pred", {31'd0, update_pred}, 32'd0);

        // Fresh mispredict, then reset in the first squash cycle.
        drive(32'h0000_0040, 32'h0000_0044, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("rstsq.flush_before", {31'd0, flush}, 32'd1);
        chk("rstsq.redirect_valid_before", {31'd0, redirect_valid}, 32'd1);
        clear_inputs();
        #1 rst = 1'b1;
        #1;
        chk("rstsq.flush", {31'd0, flush}, 32'd0);
        chk("rstsq.redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rstsq.update_pred", {31'd0, update_pred}, 32'd0);
        exp_bc = '0;
        exp_mc = '0;
        chk_counters("rstsq");
        tick();
        rst = 1'b0;
        tick();
        chk("after_rst.flush", {31'd0, flush}, 32'd0);
        chk("after_rst.redirect_pc", redirect_pc, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage control-transfer resolver. Compares the actual next PC of each branch/JAL/JALR in EX against the predicted PC carried down the pipe. Drives the synchronous update port of the `BranchPredictor` (`update_pred`, `branch_inst_address`, `resolved_next_pc`, `predictor_wrong`). On a misprediction, redirects fetch and squashes wrong-path instructions for a fixed number of cycles.

## Interface
- `FLUSH_CYCLES`, 2: cycles `flush` stays high after a mispredict (1..15).
- `CNT_WIDTH`, 32: width of the performance counters.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `ex_valid` in 1: EX holds a real instruction.
- `ex_stall` in 1: EX instruction does not advance this cycle.
- `ex_pc` in 32: PC of the EX instruction.
- `ex_pred_pc` in 32: next PC predicted at fetch for this instruction.
- `ex_is_branch` in 1: conditional branch.
- `ex_is_jal` in 1: JAL.
- `ex_is_jalr` in 1: JALR.
- `ex_taken` in 1: branch condition result; ignored unless `ex_is_branch`.
- `ex_target` in 32: computed target address.
- `update_pred` out 1: one-cycle pulse; predictor update strobe.
- `branch_inst_address` out 32: PC of the resolved instruction.
- `resolved_next_pc` out 32: actual next PC.
- `predictor_wrong` out 1: the prediction did not match the actual next PC.
- `redirect_valid` out 1: fetch must load `redirect_pc`.
- `redirect_pc` out 32: correct fetch PC.
- `flush` out 1: squash IF/ID and ID/EX contents.
- `branch_count` out CNT_WIDTH: number of resolved control instructions.
- `mispredict_count` out CNT_WIDTH: number of mispredictions.

## Operation
- **Resolve event:** `ex_valid & ~ex_stall & (ex_is_branch | ex_is_jal | ex_is_jalr) & state==IDLE`.
- **Actual next PC:**
  - branch taken: `ex_target`
  - branch not taken: `ex_pc + 4`, 32-bit wrapping
  - JAL: `ex_target`
  - JALR: `ex_target & ~1`
- **Mispredict:** actual next PC != `ex_pred_pc`, compared over the full 32 bits.
- **Predictor update:** on every resolve event, the registered outputs load `branch_inst_address=ex_pc`, `resolved_next_pc=actual`, `predictor_wrong=mispredict`, and `update_pred=1`. Otherwise `update_pred=0` and the data outputs hold their last value.
- **Counters:** `branch_count` increments on every resolve event; `mispredict_count` increments when the event also mispredicts. Both wrap modulo 2^CNT_WIDTH.
- **FSM states:**
  - IDLE → SQUASH on a mispredicting resolve event; load `sq_cnt=FLUSH_CYCLES`, register `redirect_pc=actual`.
  - SQUASH: `flush=1`. `sq_cnt` decrements every cycle regardless of `ex_stall`. On the cycle `sq_cnt==1`, return to IDLE.
  - `redirect_valid=1` only on the first SQUASH cycle.
- **In SQUASH:** all EX inputs are wrong-path and ignored; no update, no count, no new redirect.
- **Stall:** with `ex_stall=1`, no resolve event occurs, so an instruction stalled for several cycles resolves exactly once.
- **Conflicting decodes:** if more than one `ex_is_*` is high, priority is JALR > JAL > branch.

## Timing
- **Reset values (async):** all outputs 0, `state=IDLE`, `sq_cnt=0`, counters 0. Asserting `rst` mid-SQUASH drops `flush` and `redirect_valid` immediately.
- **Latency:** resolve event in cycle t → `update_pred`, `redirect_valid`, and `flush` are high in cycle t+1. Fetch loads `redirect_pc` at the end of t+1.
- `flush` is high for exactly FLUSH_CYCLES consecutive cycles, t+1..t+FLUSH_CYCLES.
- The first possible next resolve event is in cycle t+FLUSH_CYCLES+1.
- A correctly predicted event in cycle t gives `update_pred` in t+1 only, with no flush. Back-to-back correct events produce back-to-back pulses.

## Structure
- Add to `branchpredictor_def.v`:
  - `BRU_IDLE`, `BRU_SQUASH` state encodings
  - default `BRU_FLUSH_CYCLES`
- One sub-module, `bru_event_counter`: a CNT_WIDTH wrapping counter with `inc` enable and async reset. It is instantiated twice.
- Next-PC compute and compare logic stays inline.

## Test plan
1. Reset, then `ex_is_branch=1`, `ex_taken=0`, `ex_pc=0x100`, `ex_pred_pc=0x104`.
   - Next cycle: `update_pred=1`, `resolved_next_pc=0x104`, `predictor_wrong=0`, `flush=0`, `branch_count=1`.
2. Taken branch with `ex_pc=0x200`, `ex_target=0x180`, `ex_pred_pc=0x204`.
   - t+1: `redirect_valid=1`, `redirect_pc=0x180`, `predictor_wrong=1`.
   - `flush` high for t+1 and t+2.
   - `mispredict_count=1`.
3. During the SQUASH from scenario 2, present a valid JAL with a wrong prediction.
   - No `update_pred`, counters unchanged, `flush` still drops after 2 cycles.
4. JALR with `ex_target=0x3001`, `ex_pred_pc=0x3000`, held with `ex_stall=1` for 3 cycles, then released.
   - Exactly one `update_pred`, `resolved_next_pc=0x3000`, `predictor_wrong=0`.
5. Branch at `ex_pc=0xFFFFFFFC`, not taken, `ex_pred_pc=0x0`.
   - `resolved_next_pc=0x0`, no mispredict.
   - Then assert `rst` in the first SQUASH cycle of a fresh mispredict: `flush`, `redirect_valid`, and counters read 0 in that same cycle.
